// File: rtl/pipe_ripple_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple adder.
// Pipeline registers are packed into flat "triangular" vectors: stage k
// keeps (k+1) finished sum slices and (STAGES-1-k) pending operand slices,
// so every stored bit is consumed downstream. The offset helpers below give
// each stage's position inside those vectors.
package adder_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_STAGES = 4;

    // Slice width handled by one stage.
    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configuration: 1..WIDTH stages that divide WIDTH evenly.
    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Start of stage k's deskewed sum register (stage k holds sw*(k+1) bits).
    function automatic int sum_off(input int sw, input int k);
        return sw * ((k * (k + 1)) / 2);
    endfunction

    // Total bits of all deskewed sum registers.
    function automatic int sum_bits(input int sw, input int stages);
        return sw * ((stages * (stages + 1)) / 2);
    endfunction

    // Start of stage k's skewed operand register (holds sw*(stages-1-k) bits).
    function automatic int opd_off(input int sw, input int stages, input int k);
        return sw * (k * (stages - 1) - (k * (k - 1)) / 2);
    endfunction

    // Total bits of all skewed operand registers, never below one bit.
    function automatic int opd_bits(input int sw, input int stages);
        int n;
        n = sw * ((stages * (stages - 1)) / 2);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/pipe_ripple_adder_slice.sv
// adder_slice: combinational SW-bit ripple of full-adder cells. Exposes the
// carry into the top bit (c_msb) so the caller can derive signed overflow.
module adder_slice
    import adder_pkg::*;
#(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb
);

    logic [SW:0] c;

    // Ripple the carry through SW full-adder cells, LSB first.
    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SW; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[SW];
    assign c_msb = c[SW-1];

endmodule

// File: rtl/pipe_ripple_adder.sv
// pipe_ripple_adder: WIDTH-bit ripple-carry adder split into STAGES slices,
// one slice per pipeline stage, carry registered between stages.
// Valid/ready on both sides with a single global stall: every stage moves
// only when the output register is empty or being drained.
// Optional feature macro: PIPE_ADDER_SUB_EN adds the `sub` port (a - b).
module pipe_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SW       = slice_w(WIDTH, STAGES);
    localparam int SUM_BITS = sum_bits(SW, STAGES);
    localparam int OPD_BITS = opd_bits(SW, STAGES);
    localparam int LAST_SO  = sum_off(SW, STAGES - 1);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_ripple_adder: WIDTH must be a multiple of STAGES");
    end

    // Pipeline state, one entry (or one triangular segment) per stage.
    logic [STAGES-1:0]   vld_q, vld_d;
    logic [STAGES-1:0]   cy_q, cy_d;
    logic [SUM_BITS-1:0] sum_q, sum_d;
    logic [OPD_BITS-1:0] opa_q, opa_d;
    logic [OPD_BITS-1:0] opb_q, opb_d;
    logic                msb_q, msb_d;
    logic [STAGES-1:0]   slice_msb;
    logic                advance;

    // Operand B and carry-in as seen by the adder chain. Subtraction is
    // folded in here (invert B, force carry-in), so the mode travels with the
    // operands through the skew registers without a separate pipe bit.
    logic [WIDTH-1:0]    b_eff;
    logic                c0;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;
`else
    assign b_eff = b;
    assign c0    = cin;
`endif

    assign advance   = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];
    assign s         = sum_q[LAST_SO +: WIDTH];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = msb_q ^ cy_q[STAGES-1];
    assign msb_d     = slice_msb[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SO = sum_off(SW, k);
        localparam int SN = SW * (k + 1);
        localparam int OO = opd_off(SW, STAGES, k);
        localparam int ON = SW * (STAGES - 1 - k);

        logic [SW-1:0] sa, sb, ss;
        logic          sc, sco;

        if (k == 0) begin : g_head
            assign sa           = a[SW-1:0];
            assign sb           = b_eff[SW-1:0];
            assign sc           = c0;
            assign vld_d[0]     = in_valid;
            assign sum_d[0 +: SW] = ss;
            if (ON > 0) begin : g_skew
                assign opa_d[OO +: ON] = a[WIDTH-1:SW];
                assign opb_d[OO +: ON] = b_eff[WIDTH-1:SW];
            end
        end else begin : g_body
            localparam int PO  = opd_off(SW, STAGES, k - 1);
            localparam int PSO = sum_off(SW, k - 1);
            assign sa             = opa_q[PO +: SW];
            assign sb             = opb_q[PO +: SW];
            assign sc             = cy_q[k-1];
            assign vld_d[k]       = vld_q[k-1];
            // Deskew: previously finished low slices ride along below the new one.
            assign sum_d[SO +: SN] = {ss, sum_q[PSO +: SW*k]};
            if (ON > 0) begin : g_skew
                assign opa_d[OO +: ON] = opa_q[PO+SW +: ON];
                assign opb_d[OO +: ON] = opb_q[PO+SW +: ON];
            end
        end

        adder_slice #(.SW(SW)) u_slice (
            .a    (sa),
            .b    (sb),
            .cin  (sc),
            .s    (ss),
            .cout (sco),
            .c_msb(slice_msb[k])
        );

        assign cy_d[k] = sco;
    end

    if (STAGES == 1) begin : g_no_skew
        assign opa_d = '0;
        assign opb_d = '0;
    end

    // Shift the whole pipeline one stage whenever the output is free; on a
    // stall everything (including bubbles) holds in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            sum_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            msb_q <= 1'b0;
        end else if (advance) begin
            vld_q <= vld_d;
            cy_q  <= cy_d;
            sum_q <= sum_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            msb_q <= msb_d;
        end
    end

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Directed bench for pipe_ripple_adder (32/4) plus random sweeps of the
// (8,1), (8,8), (16,2), (64,4) configurations against a sign-rule model.
module tb_pipe_ripple_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_rst;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        sub_m;
    logic        out_valid, out_ready;
    logic [31:0] s;
    logic        cout, ovf;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Output transfers of the 32/4 instance, in arrival order.
    logic [31:0] mon_s[$];
    logic        mon_c[$];
    logic        mon_o[$];
    int          mon_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pipe_ripple_adder #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub      (sub_m),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        mon_s.delete(); mon_c.delete(); mon_o.delete(); mon_cyc.delete();
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            mon_s.push_back(s);
            mon_c.push_back(cout);
            mon_o.push_back(ovf);
            mon_cyc.push_back(cyc);
        end
    end

    // One op through an idle pipe; checks sum, flags and 4-cycle latency.
    task automatic run_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic c, input logic sb, input logic [31:0] es,
                           input logic ec, input logic eo);
        int t0;
        int n;
        mon_clear();
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; cin = c; sub_m = sb; t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0; sub_m = 1'b0;
        n = 0;
        while (mon_s.size() == 0 && n < 20) begin
            @(negedge clk); #2; n++;
        end
        if (mon_s.size() == 0) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_s"}, mon_s[0], es);
            chk({tag, "_cout"}, mon_c[0], ec);
            chk({tag, "_ovf"}, mon_o[0], eo);
            chk({tag, "_lat"}, mon_cyc[0] - t0, 4);
        end
    endtask

    // Back-to-back stream vectors.
    logic [31:0] st_a [4] = '{32'd100, 32'd50, 32'hFFFF_FFE2, 32'd10};
    logic [31:0] st_b [4] = '{32'hFFFF_FFCE, 32'd30, 32'hFFFF_FFEC, 32'd15};
    logic        st_ci[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] st_s [4] = '{32'd50, 32'd80, 32'hFFFF_FFCE, 32'd26};
    logic        st_c [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Backpressure vectors.
    logic [31:0] bp_a [6] = '{32'h1, 32'hFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF, 32'h4000_0000};
    logic [31:0] bp_b [6] = '{32'h2, 32'h1, 32'h1, 32'h1111_1111, 32'hFFFF, 32'h4000_0000};
    logic [31:0] bp_s [6] = '{32'h3, 32'h100, 32'h0, 32'h2345_6789, 32'h1FFFE, 32'h8000_0000};
    logic        bp_c [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        bp_o [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int t0;
        int n;
        int idx;
        logic stall;
        rst = 1'b1; sw_rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_m = 1'b0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0; sw_rst = 1'b0;

        run_one("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_one("neg_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Back-to-back stream: results on consecutive cycles 4..7.
        mon_clear();
        t0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = st_a[i]; b = st_b[i]; cin = st_ci[i];
            if (i == 0) t0 = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0; cin = 1'b0;
        n = 0;
        while (mon_s.size() < 4 && n < 20) begin @(negedge clk); #2; n++; end
        chk("stream_count", mon_s.size(), 4);
        for (int i = 0; i < 4 && i < mon_s.size(); i++) begin
            chk($sformatf("stream%0d_s", i), mon_s[i], st_s[i]);
            chk($sformatf("stream%0d_cout", i), mon_c[i], st_c[i]);
            chk($sformatf("stream%0d_ovf", i), mon_o[i], 0);
            chk($sformatf("stream%0d_cyc", i), mon_cyc[i] - t0, 4 + i);
        end

        // Backpressure: out_ready low for loop steps 5..7.
        mon_clear();
        idx = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            stall     = (t >= 5) && (t <= 7);
            out_ready = !stall;
            in_valid  = (idx < 6);
            if (idx < 6) begin a = bp_a[idx]; b = bp_b[idx]; end
            #1;
            chk($sformatf("bp_in_ready_t%0d", t), in_ready, !stall);
            if (stall) chk($sformatf("bp_hold_s_t%0d", t), s, bp_s[1]);
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", mon_s.size(), 6);
        for (int i = 0; i < 6 && i < mon_s.size(); i++) begin
            chk($sformatf("bp%0d_s", i), mon_s[i], bp_s[i]);
            chk($sformatf("bp%0d_cout", i), mon_c[i], bp_c[i]);
            chk($sformatf("bp%0d_ovf", i), mon_o[i], bp_o[i]);
        end

        // Reset with three ops in flight, the oldest already at the output.
        mon_clear();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'(i + 1); b = 32'(i + 1); cin = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("prerst_valid", out_valid, 1);
        chk("prerst_s", s, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        chk("midrst_in_ready", in_ready, 1);
        mon_clear();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("postrst_stale", mon_s.size(), 0);
        run_one("postrst_op", 32'h0, 32'h0, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0);

`ifdef PIPE_ADDER_SUB_EN
        run_one("sub_5m7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_minm1", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        run_one("sub_cin_ign", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
`endif

        n = 0;
        while (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin)
               && n < 20000) begin
            @(negedge clk); n++;
        end
        if (n >= 20000) chk("sweep_timeout", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Random sweeps over other configurations, out_ready held high.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int W = (gi == 3) ? 64 : (gi == 2) ? 16 : 8;
        localparam int S = (gi == 0) ? 1 : (gi == 1) ? 8 : (gi == 2) ? 2 : 4;

        logic         iv, ir, ov, ic, oc, oo;
        logic [W-1:0] ia, ib, os;
        logic [W:0]   full;
        logic [W+1:0] exq[$];
        int           excyc[$];
        logic         fin = 1'b0;

        pipe_ripple_adder #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk      (clk),
            .rst      (sw_rst),
            .in_valid (iv),
            .in_ready (ir),
            .a        (ia),
            .b        (ib),
            .cin      (ic),
`ifdef PIPE_ADDER_SUB_EN
            .sub      (1'b0),
`endif
            .out_valid(ov),
            .out_ready(1'b1),
            .s        (os),
            .cout     (oc),
            .ovf      (oo)
        );

        initial begin
            logic e_ovf;
            iv = 1'b0; ia = '0; ib = '0; ic = 1'b0;
            while (sw_rst !== 1'b0) @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                @(negedge clk);
                iv = ($urandom_range(3) != 0);
                ia = W'({$urandom, $urandom});
                ib = W'({$urandom, $urandom});
                ic = 1'($urandom_range(1));
                #1;
                if (iv && ir) begin
                    full  = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
                    e_ovf = (ia[W-1] == ib[W-1]) && (full[W-1] != ia[W-1]);
                    exq.push_back({e_ovf, full});
                    excyc.push_back(cyc + S);
                end
            end
            @(negedge clk);
            iv = 1'b0;
            repeat (S + 3) @(negedge clk);
            #3;
            chk($sformatf("sw%0d_drain", gi), exq.size(), 0);
            fin = 1'b1;
        end

        always begin
            logic [W+1:0] e;
            int           ec;
            @(negedge clk);
            #2;
            if (!sw_rst && ov) begin
                if (exq.size() == 0) begin
                    chk($sformatf("sw%0d_spurious", gi), 1, 0);
                end else begin
                    e  = exq.pop_front();
                    ec = excyc.pop_front();
                    chk($sformatf("sw%0d_s", gi), os, e[W-1:0]);
                    chk($sformatf("sw%0d_cout", gi), oc, e[W]);
                    chk($sformatf("sw%0d_ovf", gi), oo, e[W+1]);
                    chk($sformatf("sw%0d_lat", gi), cyc, ec);
                end
            end
        end
    end

endmodule
